// File: rtl/rotate_ctrl.sv
// Three-button rotator controller: each raw button is synchronized and debounced,
// a press toggles run/direction or steps the speed, and a speed-scaled tick paces updates.
module rotate_ctrl #(
    parameter int DB_CNT    = 1_000_000,
    parameter int TICK_BASE = 3_125_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_spd,
    output logic       en,
    output logic       dir,
    output logic [1:0] speed,
    output logic       tick
);

    localparam int DB_W   = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int TICK_W = $clog2(8 * TICK_BASE);

    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CNT - 1);
    localparam logic [TICK_W-1:0] RELOAD0 = TICK_W'(8 * TICK_BASE - 1);
    localparam logic [TICK_W-1:0] RELOAD1 = TICK_W'(4 * TICK_BASE - 1);
    localparam logic [TICK_W-1:0] RELOAD2 = TICK_W'(2 * TICK_BASE - 1);
    localparam logic [TICK_W-1:0] RELOAD3 = TICK_W'(TICK_BASE - 1);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HI,
        HIGH,
        WAIT_LO
    } db_state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_spd, btn_dir, btn_run};

    // One synchronizer + debounce FSM per button; bit 0 run, bit 1 dir, bit 2 speed.
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic            sync_a;
        logic            sync_b;
        db_state_t       state;
        db_state_t       state_nxt;
        logic [DB_W-1:0] cnt;
        logic [DB_W-1:0] cnt_nxt;
        logic            press_nxt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
                state  <= LOW;
                cnt    <= '0;
            end else begin
                sync_a <= btn_raw[i];
                sync_b <= sync_a;
                state  <= state_nxt;
                cnt    <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            press_nxt = 1'b0;
            case (state)
                LOW: begin
                    if (sync_b) begin
                        state_nxt = WAIT_HI;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_b) begin
                        state_nxt = LOW;
                    end else if (cnt == DB_LAST) begin
                        state_nxt = HIGH;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                HIGH: begin
                    if (!sync_b) begin
                        state_nxt = WAIT_LO;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_b) begin
                        state_nxt = HIGH;
                    end else if (cnt == DB_LAST) begin
                        state_nxt = LOW;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
            endcase
        end

        assign press[i] = press_nxt;
    end

    logic [1:0]        speed_inc;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] reload_new;
    logic [TICK_W-1:0] reload_cur;

    assign speed_inc = speed + 2'd1;

    function automatic logic [TICK_W-1:0] reload_for(input logic [1:0] s);
        logic [TICK_W-1:0] r;
        r = RELOAD0;
        case (s)
            2'd0: r = RELOAD0;
            2'd1: r = RELOAD1;
            2'd2: r = RELOAD2;
            2'd3: r = RELOAD3;
        endcase
        return r;
    endfunction

    assign reload_new = reload_for(speed_inc);
    assign reload_cur = reload_for(speed);

    // A speed step restarts the period from scratch so the first tick at the new rate is a full period away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            dir      <= 1'b0;
            speed    <= 2'd0;
            tick     <= 1'b0;
            tick_cnt <= RELOAD0;
        end else begin
            if (press[0]) begin
                en <= ~en;
            end
            if (press[1]) begin
                dir <= ~dir;
            end
            if (press[2]) begin
                speed    <= speed_inc;
                tick_cnt <= reload_new;
                tick     <= 1'b0;
            end else if (tick_cnt == '0) begin
                tick_cnt <= reload_cur;
                tick     <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt - TICK_W'(1);
                tick     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: constant vector table, hand-written corner sequences and
// random button traffic, all checked against a run-length / elapsed-time reference model.
module tb_rotate_ctrl;

    localparam int DB_CNT    = 4;
    localparam int TICK_BASE = 5;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_spd = 1'b0;
    logic       en;
    logic       dir;
    logic [1:0] speed;
    logic       tick;

    rotate_ctrl #(
        .DB_CNT   (DB_CNT),
        .TICK_BASE(TICK_BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_run(btn_run),
        .btn_dir(btn_dir),
        .btn_spd(btn_spd),
        .en     (en),
        .dir    (dir),
        .speed  (speed),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a button level is accepted once the synchronized input has
    // held a new value for DB_CNT+1 consecutive samples; ticks count elapsed cycles.
    int m_pipe [3][2];
    int m_prev [3];
    int m_len  [3];
    int m_acc  [3];
    int m_en, m_dir, m_speed, m_since, m_period, m_tick;

    typedef struct {
        logic run;
        logic dirb;
        logic spd;
        int   cycles;
        logic exp_en;
        logic exp_dir;
        int   exp_speed;
    } vec_t;

    vec_t vecs [14];

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            m_pipe[b][0] = 0;
            m_pipe[b][1] = 0;
            m_prev[b]    = 0;
            m_len[b]     = 0;
            m_acc[b]     = 0;
        end
        m_en     = 0;
        m_dir    = 0;
        m_speed  = 0;
        m_since  = 0;
        m_period = 8 * TICK_BASE;
        m_tick   = 0;
    endfunction

    function automatic void model_edge(input int r, input int d, input int s);
        int raw [3];
        int pressed [3];
        int synced;
        raw[0] = r;
        raw[1] = d;
        raw[2] = s;
        for (int b = 0; b < 3; b++) begin
            pressed[b]   = 0;
            synced       = m_pipe[b][1];
            m_pipe[b][1] = m_pipe[b][0];
            m_pipe[b][0] = raw[b];
            if (synced == m_prev[b]) m_len[b] = m_len[b] + 1;
            else                     m_len[b] = 1;
            m_prev[b] = synced;
            if (synced != m_acc[b] && m_len[b] >= DB_CNT + 1) begin
                m_acc[b]   = synced;
                pressed[b] = synced;
            end
        end
        if (pressed[0] != 0) m_en  = 1 - m_en;
        if (pressed[1] != 0) m_dir = 1 - m_dir;
        if (pressed[2] != 0) begin
            m_speed  = (m_speed + 1) % 4;
            m_period = TICK_BASE * (8 / (1 << m_speed));
            m_since  = 0;
            m_tick   = 0;
        end else begin
            m_since = m_since + 1;
            if (m_since == m_period) begin
                m_tick  = 1;
                m_since = 0;
            end else begin
                m_tick = 0;
            end
        end
    endfunction

    task automatic check_eq(input string name, input logic [31:0] actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_eq({tag, " en"},    en,    m_en);
        check_eq({tag, " dir"},   dir,   m_dir);
        check_eq({tag, " speed"}, speed, m_speed);
        check_eq({tag, " tick"},  tick,  m_tick);
    endtask

    // Called at a falling edge; drives the buttons for one clock and checks at the next falling edge.
    task automatic applyStimulus(input logic r, input logic d, input logic s, input string tag);
        btn_run = r;
        btn_dir = d;
        btn_spd = s;
        @(posedge clk);
        model_edge(int'(r), int'(d), int'(s));
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         pat [6];
        int         exp_per [4];
        int         n;
        logic       got;
        logic [2:0] bits;
        int         len;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1,  3, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0,  8, 1'b0, 1'b1, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 2};

        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset en",    en,    0);
        check_eq("reset dir",   dir,   0);
        check_eq("reset speed", speed, 0);
        check_eq("reset tick",  tick,  0);
        reset = 1'b1;

        // Idle after release: ticks exactly every 40 cycles, first at 40.
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, "idle");
            check_eq("idle tick", tick, (i % 40 == 0) ? 1 : 0);
        end

        for (int v = 0; v < 14; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                applyStimulus(vecs[v].run, vecs[v].dirb, vecs[v].spd, "table");
            end
            check_eq($sformatf("vec%0d en", v),    en,    int'(vecs[v].exp_en));
            check_eq($sformatf("vec%0d dir", v),   dir,   int'(vecs[v].exp_dir));
            check_eq($sformatf("vec%0d speed", v), speed, vecs[v].exp_speed);
        end

        // Press latency: en (currently 1) flips exactly on the 7th edge after the raw rise.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, "latency");
            check_eq("run latency en", en, (i < 7) ? 1 : 0);
        end
        repeat (13) applyStimulus(1'b1, 1'b0, 1'b0, "hold");
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, "release");
        check_eq("run hold/release en", en, 0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, "second press");
        check_eq("run second press en", en, 1);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, "gap");

        // Bounce on btn_dir: toggle only after a clean run following the last glitch.
        pat = '{1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, logic'(pat[i]), 1'b0, "bounce");
            check_eq("bounce dir", dir, 0);
        end
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, "settle");
            check_eq("bounce settle dir", dir, (6 + i >= 12) ? 1 : 0);
        end
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, "gap");

        // Simultaneous run and dir presses land on the same edge.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, "simultaneous");
            check_eq("simul en",  en,  (i < 7) ? 1 : 0);
            check_eq("simul dir", dir, (i < 7) ? 1 : 0);
        end
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, "gap");

        // Reset while btn_run is mid-debounce and the tick period is part-way through.
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, "pre-reset");
        btn_run = 1'b0;
        reset   = 1'b0;
        #1;
        check_eq("async reset en",    en,    0);
        check_eq("async reset dir",   dir,   0);
        check_eq("async reset speed", speed, 0);
        check_eq("async reset tick",  tick,  0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, "post-reset");
            check_eq("post-reset tick", tick, (i == 40) ? 1 : 0);
        end
        check_eq("post-reset en", en, 0);

        // Four speed presses: 1,2,3,0 with periods 20,10,5,40 and no tick on the change edge.
        exp_per = '{20, 10, 5, 40};
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= 7; c++) begin
                applyStimulus(1'b0, 1'b0, 1'b1, "speed press");
                if (c == 6) check_eq("speed before change", speed, k);
                if (c == 7) begin
                    check_eq("speed after change", speed, (k + 1) % 4);
                    check_eq("change-cycle tick", tick, 0);
                end
            end
            n   = 0;
            got = 1'b0;
            while (n < 100 && !got) begin
                applyStimulus(1'b0, 1'b0, 1'b0, "period");
                n++;
                got = (tick === 1'b1);
            end
            check_eq($sformatf("tick period at speed %0d", (k + 1) % 4), n, exp_per[k]);
            repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, "gap");
        end

        // Random button traffic with hold lengths spanning both sides of the debounce window.
        for (int seg = 0; seg < 150; seg++) begin
            bits = 3'($urandom_range(0, 7));
            len  = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) begin
                applyStimulus(bits[0], bits[1], bits[2], "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
